product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter N_TERMS, default 4: products summed per result; SHALL be >= 1.
REQ-002 Parameter ACC_W, default 10: accumulator and result width; SHALL be >= 8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous abort; discards the partial sum.
REQ-006 in_valid  input  1  in_product is valid.
REQ-007 in_ready  output  1  block can accept in_product.
REQ-008 in_product  input  8  unsigned 4x4 multiplier product.
REQ-009 out_valid  output  1  out_sum and out_ovf are valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_sum  output  ACC_W  unsigned sum of N_TERMS products.
REQ-012 out_ovf  output  1  overflow occurred during this result.

Function
REQ-013 Input transfer SHALL occur when in_valid && in_ready at a clock edge; output transfer SHALL occur when out_valid && out_ready.
REQ-014 FSM SHALL have three states: IDLE (count 0), ACCUM (0 < count < N_TERMS), HOLD (result presented).
REQ-015 IDLE/ACCUM: in_ready = !clr; out_valid = 0.
REQ-016 HOLD: in_ready = 0; out_valid = 1.
REQ-017 On an input transfer: acc <= acc + zero-extended in_product; count <= count + 1.
REQ-018 The N_TERMS-th transfer SHALL move the FSM to HOLD; out_valid SHALL rise the cycle after that transfer (latency 1).
REQ-019 With N_TERMS = 1: IDLE -> HOLD on every transfer.
REQ-020 In HOLD, out_sum and out_ovf SHALL remain stable until the output transfer.
REQ-021 On the output transfer: FSM -> IDLE; acc, count and ovf cleared. Minimum throughput: one result per N_TERMS+1 cycles.
REQ-022 clr in IDLE/ACCUM: no input transfer; next state IDLE; acc, count and ovf cleared.
REQ-023 clr in HOLD SHALL be ignored; the pending result is not dropped.
REQ-024 ovf SHALL be sticky per result: set when any addition carries out of ACC_W bits.
REQ-025 in_ready SHALL have no combinational path from out_ready.

Reset
REQ-026 While rst_n = 0: FSM = IDLE; acc = 0; count = 0; ovf = 0; out_valid = 0; out_sum = 0; out_ovf = 0; in_ready = 0.
REQ-027 Deassertion SHALL take effect at the first clock edge after rst_n rises; in_ready = 1 from that cycle.
REQ-028 Reset asserted mid-operation SHALL discard partial and pending results without emitting an output transfer.

Configuration
REQ-029 Macro PACC_SATURATE_EN defined: on carry-out, acc SHALL clamp to 2^ACC_W-1 and stay there until cleared; ovf SHALL be set.
REQ-030 Macro PACC_SATURATE_EN undefined: acc SHALL wrap modulo 2^ACC_W; ovf SHALL still be set on carry-out.

Structure
REQ-031 Shared package pacc_pkg SHALL hold: PROD_W = 8; the state enum {IDLE, ACCUM, HOLD}; and the count-width function clog2(N_TERMS+1).
REQ-032 One sub-module, pacc_sat_add, SHALL implement the ACC_W adder with carry-out and the saturate/wrap selection. All other logic stays in product_accumulator.

Verification
REQ-033 Defaults, products 225,225,225,225 back-to-back, out_ready = 1 -> out_valid high in cycle 5, out_sum = 900, out_ovf = 0.
REQ-034 Products 10,20,30,40 with out_ready held low 3 cycles -> out_sum = 100 held stable, in_ready = 0 throughout HOLD, IDLE the cycle after the transfer.
REQ-035 Products 50,60 then clr, then 1,2,3,4 -> out_sum = 10; clr asserted together with in_valid -> no transfer.
REQ-036 ACC_W = 8, N_TERMS = 2, products 200,100 -> with PACC_SATURATE_EN: out_sum = 255, out_ovf = 1; without: out_sum = 44, out_ovf = 1.
REQ-037 rst_n pulsed low after 3 accepted products -> outputs zero immediately; the next 4 products 1,1,1,1 give out_sum = 4.
REQ-038 N_TERMS = 1, products 7 then 9 with out_ready = 1 -> two results, 7 then 9, each with one idle cycle between them.

Source files
------------

// File: rtl/pacc_pkg.sv
// Shared types and constants for the product accumulator.
package pacc_pkg;

    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } pacc_state_e;

    // Ceiling log2, never less than one bit so a counter always has a width.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/pacc_sat_add.sv
// Accumulator adder with carry-out; clamps to all-ones on carry when
// PACC_SATURATE_EN is defined, otherwise wraps modulo 2^ACC_W.
module pacc_sat_add
    import pacc_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_addend,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    logic [ACC_W:0] w_wide;

    assign w_wide  = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_addend};
    assign o_carry = w_wide[ACC_W];

`ifdef PACC_SATURATE_EN
    assign o_sum = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
`else
    assign o_sum = w_wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums N_TERMS 8-bit products into one ACC_W-bit result with sticky overflow.
// Optional macro PACC_SATURATE_EN selects saturating instead of wrapping sums.
module product_accumulator
    import pacc_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int CNT_W = clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

    pacc_state_e      r_state;
    pacc_state_e      w_next_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_live;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic             w_in_xfer;
    logic             w_out_xfer;

    pacc_sat_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .i_acc   (r_acc),
        .i_addend(in_product),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // r_live holds in_ready low until the first edge after reset release.
    assign in_ready   = r_live && (r_state != HOLD) && !clr;
    assign out_valid  = (r_state == HOLD);
    assign out_sum    = r_acc;
    assign out_ovf    = r_ovf;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (clr) begin
                    w_next_state = IDLE;
                end else if (w_in_xfer) begin
                    w_next_state = (w_cnt_inc == LAST_CNT) ? HOLD : ACCUM;
                end else begin
                    w_next_state = r_state;
                end
            end
            HOLD: begin
                if (w_out_xfer) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = HOLD;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Accumulator, term count and sticky overflow; clr cannot touch a held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= {ACC_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_ovf <= 1'b0;
        end else if (w_out_xfer || ((r_state != HOLD) && clr)) begin
            r_acc <= {ACC_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_ovf <= 1'b0;
        end else if (w_in_xfer) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_carry;
        end
    end

    // Ready qualifier released one edge after reset deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: reference model for the default instance plus directed
// literal checks on small-parameter instances.
module tb_product_accumulator;

    localparam int    N_A   = 4;
    localparam int    W_A   = 10;
    localparam longint MAX_A = (64'd1 << W_A) - 1;

    logic clk;
    logic rst_n;

    logic       a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [7:0] a_in_product;
    logic [9:0] a_out_sum;

    logic       b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [7:0] b_in_product;
    logic [7:0] b_out_sum;

    logic       c_clr, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
    logic [7:0] c_in_product;
    logic [9:0] c_out_sum;

    int errors = 0;
    int checks = 0;

    product_accumulator #(.N_TERMS(N_A), .ACC_W(W_A)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_product(a_in_product), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_sum(a_out_sum), .out_ovf(a_out_ovf)
    );

    product_accumulator #(.N_TERMS(2), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_product(b_in_product), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_sum(b_out_sum), .out_ovf(b_out_ovf)
    );

    product_accumulator #(.N_TERMS(1), .ACC_W(10)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(c_clr), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .in_product(c_in_product), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_sum(c_out_sum), .out_ovf(c_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: number of accepted terms and their exact (unbounded) total.
    int     m_cnt;
    longint m_total;
    bit     m_live;

    function automatic logic [31:0] exp_sum(input longint total);
`ifdef PACC_SATURATE_EN
        return (total > MAX_A) ? 32'(MAX_A) : 32'(total);
`else
        return 32'(total % (MAX_A + 1));
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_total <= 0;
            m_live  <= 1'b0;
        end else begin
            m_live <= 1'b1;
            if (m_cnt == N_A) begin
                if (a_out_ready) begin
                    m_cnt   <= 0;
                    m_total <= 0;
                end
            end else if (m_live && a_clr) begin
                m_cnt   <= 0;
                m_total <= 0;
            end else if (m_live && a_in_valid) begin
                m_cnt   <= m_cnt + 1;
                m_total <= m_total + longint'(a_in_product);
            end
        end
    end

    always @(negedge clk) begin
        chk("model_in_ready", {31'd0, a_in_ready}, {31'd0, (m_live && (m_cnt < N_A) && !a_clr)});
        chk("model_out_valid", {31'd0, a_out_valid}, {31'd0, (m_cnt == N_A)});
        if (!rst_n || (m_cnt == N_A)) begin
            chk("model_out_sum", {22'd0, a_out_sum}, exp_sum(m_total));
            chk("model_out_ovf", {31'd0, a_out_ovf}, {31'd0, (m_total > MAX_A)});
        end
    end

    initial begin
        rst_n = 1'b0;
        {a_clr, a_in_valid, a_out_ready} = 3'b000;
        {b_clr, b_in_valid, b_out_ready} = 3'b000;
        {c_clr, c_in_valid, c_out_ready} = 3'b000;
        a_in_product = 8'd0;
        b_in_product = 8'd0;
        c_in_product = 8'd0;
        repeat (2) tick();
        chk("reset_in_ready", {31'd0, a_in_ready}, 32'd0);
        chk("reset_out_sum", {22'd0, a_out_sum}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready_low", {31'd0, a_in_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("release_in_ready_high", {31'd0, a_in_ready}, 32'd1);

        // Four maximum products back-to-back.
        tick();
        a_out_ready  = 1'b1;
        a_in_valid   = 1'b1;
        a_in_product = 8'd225;
        repeat (4) tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("t225_valid", {31'd0, a_out_valid}, 32'd1);
        chk("t225_sum", {22'd0, a_out_sum}, 32'd900);
        chk("t225_ovf", {31'd0, a_out_ovf}, 32'd0);
        tick();

        // Result held while downstream stalls.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_in_product = 8'(10 * i);
            tick();
        end
        a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_sum", {22'd0, a_out_sum}, 32'd100);
            chk("hold_in_ready", {31'd0, a_in_ready}, 32'd0);
            tick();
        end
        a_out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("hold_release_valid", {31'd0, a_out_valid}, 32'd0);
        chk("hold_release_in_ready", {31'd0, a_in_ready}, 32'd1);

        // Abort a partial sum; clr with in_valid must not transfer.
        a_in_valid   = 1'b1;
        a_in_product = 8'd50;
        tick();
        a_in_product = 8'd60;
        tick();
        a_in_product = 8'd99;
        a_clr        = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", {31'd0, a_in_ready}, 32'd0);
        tick();
        a_clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            a_in_product = 8'(i);
            tick();
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("clr_sum", {22'd0, a_out_sum}, 32'd10);
        chk("clr_valid", {31'd0, a_out_valid}, 32'd1);
        tick();

        // Reset in the middle of a result.
        a_in_valid = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            a_in_product = 8'(i);
            tick();
        end
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", {22'd0, a_out_sum}, 32'd0);
        chk("midrst_valid", {31'd0, a_out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, a_in_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        a_in_valid   = 1'b1;
        a_in_product = 8'd1;
        repeat (4) tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_next_sum", {22'd0, a_out_sum}, 32'd4);
        chk("midrst_next_valid", {31'd0, a_out_valid}, 32'd1);
        tick();

        // Narrow accumulator overflow.
        b_out_ready  = 1'b1;
        b_in_valid   = 1'b1;
        b_in_product = 8'd200;
        tick();
        b_in_product = 8'd100;
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("w8_valid", {31'd0, b_out_valid}, 32'd1);
`ifdef PACC_SATURATE_EN
        chk("w8_sum", {24'd0, b_out_sum}, 32'd255);
`else
        chk("w8_sum", {24'd0, b_out_sum}, 32'd44);
`endif
        chk("w8_ovf", {31'd0, b_out_ovf}, 32'd1);
        tick();
        @(negedge clk);
        chk("w8_ovf_cleared", {31'd0, b_out_ovf}, 32'd0);

        // Single-term results with an idle cycle between them.
        tick();
        c_out_ready  = 1'b1;
        c_in_valid   = 1'b1;
        c_in_product = 8'd7;
        tick();
        @(negedge clk);
        chk("n1_first_valid", {31'd0, c_out_valid}, 32'd1);
        chk("n1_first_sum", {22'd0, c_out_sum}, 32'd7);
        chk("n1_first_in_ready", {31'd0, c_in_ready}, 32'd0);
        tick();
        c_in_product = 8'd9;
        @(negedge clk);
        chk("n1_gap_valid", {31'd0, c_out_valid}, 32'd0);
        chk("n1_gap_in_ready", {31'd0, c_in_ready}, 32'd1);
        tick();
        c_in_valid = 1'b0;
        @(negedge clk);
        chk("n1_second_valid", {31'd0, c_out_valid}, 32'd1);
        chk("n1_second_sum", {22'd0, c_out_sum}, 32'd9);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            a_in_valid   = ($urandom_range(0, 3) != 0);
            a_in_product = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
            a_clr        = ($urandom_range(0, 15) == 0);
            a_out_ready  = ($urandom_range(0, 3) != 0);
            rst_n        = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        {a_clr, a_in_valid, a_out_ready} = 3'b000;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
